// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial receive/transmit blocks.
//   state_t   : 2-bit frame state encoding
//   S_IDLE / S_START / S_DATA / S_STOP : frame states
//   LINE_IDLE : level of the serial line when no frame is in flight
// -----------------------------------------------------------------------------
package serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_START = 2'd1;
   localparam state_t S_DATA  = 2'd2;
   localparam state_t S_STOP  = 2'd3;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous inputs, one chain per bit.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-high reset; both flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronised output, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg[gi] <= RESET_VAL[gi];
               sync_reg[gi] <= RESET_VAL[gi];
            end else begin
               meta_reg[gi] <= d[gi];
               sync_reg[gi] <= meta_reg[gi];
            end
         end
      end
   endgenerate

   assign q = sync_reg;

endmodule

// File: rtl/serial_byte_rx.sv
// -----------------------------------------------------------------------------
// serial_byte_rx
// Oversampling serial frame receiver: start bit, DATA_BITS data bits (LSB
// first), one stop bit, idle-high line. All timing is derived from clk.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset (aborts any frame in flight)
//   rx_in      : asynchronous serial line
//   data_out   : last correctly framed word, held between frames
//   data_valid : one-cycle pulse, data_out updated in the same cycle
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   busy       : registered "state is not IDLE"
// -----------------------------------------------------------------------------
module serial_byte_rx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   logic rx_s;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [BW-1:0]        idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next, shift_in;
   logic [DATA_BITS-1:0] data_reg;
   logic                 valid_reg, err_reg, busy_reg;

   logic sample_bit;
   logic stop_tick;
   logic valid_set;
   logic err_set;

   // Synchroniser idles high so reset never looks like a start bit.
   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (LINE_IDLE)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (rx_s == 1'b0) state_next = S_START;
         end
         S_START: begin
            // Re-check the line at mid start bit; a high level means glitch.
            if (cnt_reg == CNT_HALF) state_next = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (cnt_reg == CNT_LAST && idx_reg == IDX_LAST) state_next = S_STOP;
         end
         S_STOP: begin
            // Leave at mid stop bit so a directly following start edge is seen.
            if (cnt_reg == CNT_LAST) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      sample_bit = (state_reg == S_DATA) && (cnt_reg == CNT_LAST);
      stop_tick  = (state_reg == S_STOP) && (cnt_reg == CNT_LAST);
      valid_set  = stop_tick && rx_s;
      err_set    = stop_tick && !rx_s;
   end

   // ----------------------------------------------------------- datapath next
   // Start bit lands a half bit ahead, so every later sample hits a bit centre
   // after a full CLKS_PER_BIT count.
   generate
      if (DATA_BITS == 1) begin : g_shift_one
         assign shift_in = rx_s;
      end else begin : g_shift_many
         assign shift_in = {rx_s, shift_reg[DATA_BITS-1:1]};
      end
   endgenerate

   always_comb begin
      cnt_next   = cnt_reg + CW'(1);
      idx_next   = idx_reg;
      shift_next = shift_reg;

      if (state_reg == S_IDLE || state_next != state_reg || sample_bit)
         cnt_next = '0;

      if (state_reg == S_START && state_next == S_DATA)
         idx_next = '0;
      else if (sample_bit)
         idx_next = idx_reg + BW'(1);

      if (sample_bit)
         shift_next = shift_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
      end else begin
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
      end
   end

   // ------------------------------------------------------- registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         valid_reg <= valid_set;
         err_reg   <= err_set;
         busy_reg  <= (state_reg != S_IDLE);
         if (valid_set) data_reg <= shift_reg;
      end
   end

   assign data_out   = data_reg;
   assign data_valid = valid_reg;
   assign frame_err  = err_reg;
   assign busy       = busy_reg;

endmodule
